pwm_capture: RTL and testbench
==============================

# pwm_capture

Measures an incoming PWM waveform and recovers its duty value and period in clock cycles. It is the receive-side counterpart of `pwm_generator`, used for loopback checking and for decoding externally supplied PWM control signals. Results are reported once per PWM period with a one-cycle valid strobe. Constant-level inputs, meaning 0 % or 100 % duty with no edges, are detected by a timeout.

## Interface
- `WIDTH`, 8, duty resolution in bits; nominal PWM period is 2^WIDTH clocks.
- `TIMEOUT`, 2^(WIDTH+1), number of clocks without a rising edge before a stuck-level report.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: capture enable; low forces IDLE.
- `pwm_in` in 1: asynchronous PWM input.
- `duty` out WIDTH: measured high-time, saturated to 2^WIDTH-1.
- `period` out WIDTH+2: measured rising-to-rising interval in clocks; 0 on a stuck report.
- `valid` out 1: one-cycle strobe; `duty`, `period` and `stuck` are updated in the same cycle.
- `stuck` out 1: the last report was produced by timeout; `duty` then encodes the level.

## Operation
- Input path: 2-flop synchronizer, then a registered delay flop; `rise` = sync & ~delay.
- FSM states:
  - IDLE: counters cleared.
  - ARM: wait for the first `rise`, which discards the partial period.
  - MEAS: counting.
  - STUCK: a timeout has been reported.
- FSM transitions:
  - IDLE -> ARM when `enable`=1.
  - ARM -> MEAS on `rise`, clearing the counters.
  - MEAS -> MEAS on `rise`: report, then clear the counters. `period_cnt` restarts at 1 and `high_cnt` at 1, because the rise cycle counts as high.
  - ARM or MEAS -> STUCK when `period_cnt` reaches TIMEOUT with no `rise`. Produce one report: `valid`=1, `stuck`=1, `period`=0, `duty`=0 if the synced level is low, or all-ones if high.
  - STUCK -> MEAS on `rise`, counters cleared, no report. No further reports are made while in STUCK.
  - Any state -> IDLE when `enable`=0. An in-flight measurement is abandoned, `valid`=0, and `duty`/`period`/`stuck` hold their last values.
- Counters (WIDTH+2 bits):
  - `period_cnt` increments every MEAS/ARM cycle and saturates at TIMEOUT.
  - `high_cnt` increments in each MEAS cycle where the synced level is high, and saturates.
- Report on `rise` in MEAS:
  - `period` = `period_cnt`.
  - `duty` = min(`high_cnt`, 2^WIDTH-1).
  - `stuck` = 0.
- Simultaneous `rise` and timeout in the same cycle: the `rise` wins and a normal report is made.
- Reset values: `duty`=0, `period`=0, `valid`=0, `stuck`=0, FSM=IDLE, synchronizer flops=0.

## Timing
- Latency from the first clock edge sampling `pwm_in` high to `valid`: 3 cycles (two synchronizer stages plus the registered report).
- The latency is constant, so measured widths are exact in clock cycles.
- After `enable` rises, the first normal report comes at the second rising edge of `pwm_in`. The earliest report is therefore one full period plus 3 cycles.
- Minimum resolvable high or low time: 1 clock. Shorter pulses may be lost in the synchronizer.

## Configuration
- `PWM_CAPTURE_GLITCH_FILTER_EN`:
  - Defined: a 3-sample majority filter is inserted after the synchronizer. Latency becomes 4 cycles, and single-cycle glitches are suppressed.
  - Undefined: the filter is absent and latency is 3 cycles.
- Counting and report behaviour are otherwise identical with and without the macro.

## Structure
- Shared package `pwm_pkg`:
  - FSM state enum (IDLE, ARM, MEAS, STUCK).
  - Counter-width constant WIDTH+2.
  - Default TIMEOUT expression.
- Sub-module `pwm_in_sync`: synchronizer, optional majority filter, delay flop and `rise` output. Reused by any future PWM input block.

## Test plan
- Loopback with `pwm_generator`, WIDTH=8, `duty`=64 -> every report has `duty`=64, `period`=256, `stuck`=0.
- Sweep generator `duty` over 0, 128, 192, 255:
  - 0 -> one stuck report, `duty`=0, `period`=0, then silence.
  - 128, 192, 255 -> `duty` equals the setting and `period`=256.
- Constant `pwm_in`=1 for 600 clocks -> exactly one report 512 cycles after the last rise, with `stuck`=1 and `duty`=255.
- Drop `enable` mid-period for 10 cycles, then re-enable -> no report while disabled; the first report comes after one full period and is correct.
- Assert `rst` mid-measurement -> all outputs are 0 immediately (asynchronously); capture resumes correctly after release.
- With `PWM_CAPTURE_GLITCH_FILTER_EN` defined, inject a 1-cycle high glitch in the low phase -> the report is unchanged (`duty`=64, `period`=256). Without the macro, the glitch produces a short period report.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for PWM receive-side blocks: capture FSM states,
// counter sizing and the default stuck-level timeout.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        MEAS  = 2'd2,
        STUCK = 2'd3
    } pwm_state_e;

    // Counters carry two bits above the duty resolution so that the timeout
    // (twice the nominal period) is representable.
    localparam int CNT_EXTRA_W = 2;

    function automatic int pwm_cnt_width(input int width);
        return width + CNT_EXTRA_W;
    endfunction

    function automatic int pwm_timeout_default(input int width);
        return 2 ** (width + 1);
    endfunction

endpackage

// File: rtl/pwm_in_sync.sv
// Brings an asynchronous PWM input into the clock domain and flags rising edges.
// With PWM_CAPTURE_GLITCH_FILTER_EN defined, a 3-sample majority filter follows the synchronizer.
module pwm_in_sync (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic dly_q;
    logic level;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= pwm_i;
            sync_q <= meta_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // Majority of the current and two previous synced samples: a lone
    // one-cycle pulse never wins, longer pulses pass one cycle later.
    logic [1:0] hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sync_q};
        end
    end

    assign level = (sync_q & hist_q[0]) | (sync_q & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign level = sync_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_q <= 1'b0;
        end else begin
            dly_q <= level;
        end
    end

    assign level_o = level;
    assign rise_o  = level & ~dly_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures duty (high time) and period of a PWM input, reporting once per period;
// edge-free inputs are reported by timeout. Optional PWM_CAPTURE_GLITCH_FILTER_EN adds input filtering.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = pwm_timeout_default(WIDTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     pwm_in,
    output logic [WIDTH-1:0]         duty,
    output logic [WIDTH+CNT_EXTRA_W-1:0] period,
    output logic                     valid,
    output logic                     stuck
);

    localparam int            CW       = pwm_cnt_width(WIDTH);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
    localparam logic [CW-1:0] HIGH_MAX = '1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    pwm_state_e    state_q, state_d;
    logic [CW-1:0] period_cnt_q, period_cnt_d;
    logic [CW-1:0] high_cnt_q, high_cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [CW-1:0] period_q, period_d;
    logic          valid_q, valid_d;
    logic          stuck_q, stuck_d;
    logic          level;
    logic          rise;
    logic          timeout;

    pwm_in_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .pwm_i   (pwm_in),
        .level_o (level),
        .rise_o  (rise)
    );

    function automatic logic [CW-1:0] inc_sat(input logic [CW-1:0] c, input logic [CW-1:0] lim);
        return (c >= lim) ? lim : c + 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] sat_duty(input logic [CW-1:0] c);
        return (c > CW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : c[WIDTH-1:0];
    endfunction

    assign timeout = (period_cnt_q == TMO);

    always_comb begin
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        high_cnt_d   = high_cnt_q;
        duty_d       = duty_q;
        period_d     = period_q;
        stuck_d      = stuck_q;
        valid_d      = 1'b0;

        if (!enable) begin
            state_d      = IDLE;
            period_cnt_d = '0;
            high_cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    period_cnt_d = '0;
                    high_cnt_d   = '0;
                    state_d      = ARM;
                end
                ARM, MEAS: begin
                    if (rise) begin
                        if (state_q == MEAS) begin
                            valid_d  = 1'b1;
                            stuck_d  = 1'b0;
                            period_d = period_cnt_q;
                            duty_d   = sat_duty(high_cnt_q);
                        end
                        // The rise cycle is the first high cycle of the new period.
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                        state_d      = MEAS;
                    end else if (timeout) begin
                        valid_d  = 1'b1;
                        stuck_d  = 1'b1;
                        period_d = '0;
                        duty_d   = level ? {WIDTH{1'b1}} : '0;
                        state_d  = STUCK;
                    end else begin
                        period_cnt_d = inc_sat(period_cnt_q, TMO);
                        if (state_q == MEAS && level) begin
                            high_cnt_d = inc_sat(high_cnt_q, HIGH_MAX);
                        end
                    end
                end
                STUCK: begin
                    if (rise) begin
                        period_cnt_d = CNT_ONE;
                        high_cnt_d   = CNT_ONE;
                        state_d      = MEAS;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
        end
    end

    assign duty   = duty_q;
    assign period = period_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: drives PWM patterns, records every report
// and compares against hand-computed duty/period/stuck values.
module tb_pwm_capture;

    localparam int WIDTH = 8;
    localparam int CW    = WIDTH + 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             pwm_in;
    logic [WIDTH-1:0] duty;
    logic [CW-1:0]    period;
    logic             valid;
    logic             stuck;

    always #5 clk = ~clk;

    pwm_capture #(.WIDTH(WIDTH), .TIMEOUT(512)) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .pwm_in (pwm_in),
        .duty   (duty),
        .period (period),
        .valid  (valid),
        .stuck  (stuck)
    );

    typedef struct {
        int d;
        int p;
        int s;
        int c;
    } rep_t;

    rep_t reps[$];
    rep_t rec_r;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   sweep[3] = '{128, 192, 255};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            rec_r.d = int'(duty);
            rec_r.p = int'(period);
            rec_r.s = int'(stuck);
            rec_r.c = cyc;
            reps.push_back(rec_r);
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rep(input string tag, input int i, input int d, input int p, input int s);
        if (i < reps.size()) begin
            chk($sformatf("%s[%0d].duty", tag, i), reps[i].d, d);
            chk($sformatf("%s[%0d].period", tag, i), reps[i].p, p);
            chk($sformatf("%s[%0d].stuck", tag, i), reps[i].s, s);
        end else begin
            chk($sformatf("%s[%0d].present", tag, i), reps.size(), i + 1);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_periods(input int h, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                pwm_in = (i < h);
                tick(1);
            end
        end
    endtask

    initial begin
        int prev;
        rst    = 1'b1;
        enable = 1'b0;
        pwm_in = 1'b0;
        #12;
        chk("rst.duty", int'(duty), 0);
        chk("rst.period", int'(period), 0);
        chk("rst.valid", int'(valid), 0);
        chk("rst.stuck", int'(stuck), 0);

        @(posedge clk);
        #1;
        rst    = 1'b0;
        enable = 1'b1;
        tick(20);

        // Loopback at duty 64: the first rise only arms.
        reps.delete();
        run_periods(64, 256, 4);
        chk("loop.count", reps.size(), 3);
        for (int i = 0; i < 3; i++) chk_rep("loop", i, 64, 256, 0);

        // Duty sweep; each segment's first report closes the previous setting.
        prev = 64;
        for (int k = 0; k < 3; k++) begin
            reps.delete();
            run_periods(sweep[k], 256, 3);
            chk($sformatf("sweep%0d.count", sweep[k]), reps.size(), 3);
            chk_rep("sweep", 0, prev, 256, 0);
            chk_rep("sweep", 1, sweep[k], 256, 0);
            chk_rep("sweep", 2, sweep[k], 256, 0);
            prev = sweep[k];
        end

        // Duty 0: one stuck-low report, then silence.
        reps.delete();
        pwm_in = 1'b0;
        tick(600);
        chk("low.count", reps.size(), 1);
        chk_rep("low", 0, 0, 0, 1);

        // Constant high after two normal periods.
        reps.delete();
        run_periods(64, 256, 2);
        pwm_in = 1'b1;
        tick(600);
        chk("high.count", reps.size(), 3);
        chk_rep("high", 0, 64, 256, 0);
        chk_rep("high", 1, 64, 256, 0);
        chk_rep("high", 2, 255, 0, 1);
        if (reps.size() >= 3) chk("high.gap", reps[2].c - reps[1].c, 512);
        chk("high.stuck_out", int'(stuck), 1);
        pwm_in = 1'b0;
        tick(20);

        // Enable dropped mid-period for 10 cycles.
        reps.delete();
        run_periods(64, 256, 1);
        for (int i = 0; i < 100; i++) begin
            pwm_in = (i < 64);
            tick(1);
        end
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("dis.valid", int'(valid), 0);
        end
        chk("dis.count", reps.size(), 1);
        chk("dis.duty_hold", int'(duty), 64);
        chk("dis.period_hold", int'(period), 256);
        chk("dis.stuck_hold", int'(stuck), 0);
        enable = 1'b1;
        pwm_in = 1'b0;
        tick(156);
        run_periods(64, 256, 3);
        chk("reen.count", reps.size(), 3);
        for (int i = 0; i < 3; i++) chk_rep("reen", i, 64, 256, 0);

        // Asynchronous reset in the middle of a high phase.
        for (int i = 0; i < 30; i++) begin
            pwm_in = 1'b1;
            tick(1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst.duty", int'(duty), 0);
        chk("arst.period", int'(period), 0);
        chk("arst.valid", int'(valid), 0);
        chk("arst.stuck", int'(stuck), 0);
        pwm_in = 1'b0;
        tick(3);
        chk("arst.valid_held", int'(valid), 0);
        rst = 1'b0;
        tick(50);
        reps.delete();
        run_periods(64, 256, 3);
        chk("post_rst.count", reps.size(), 2);
        chk_rep("post_rst", 0, 64, 256, 0);
        chk_rep("post_rst", 1, 64, 256, 0);

        // One-cycle glitch in the low phase.
        reps.delete();
        for (int i = 0; i < 256; i++) begin
            pwm_in = (i < 64) || (i == 150);
            tick(1);
        end
        run_periods(64, 256, 2);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        chk("glitch.count", reps.size(), 3);
        for (int i = 0; i < 3; i++) chk_rep("glitch", i, 64, 256, 0);
`else
        chk("glitch.count", reps.size(), 4);
        chk_rep("glitch", 0, 64, 256, 0);
        chk_rep("glitch", 1, 64, 150, 0);
        chk_rep("glitch", 2, 1, 106, 0);
        chk_rep("glitch", 3, 64, 256, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
